// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared definitions for the PS/2 scan-code sequencer.
//                The parser state encoding, the two PS/2 prefix byte values,
//                and a helper that sizes the prefix timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   // Parser states: plain, after E0, after F0, after E0 F0.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // The counter only needs to reach cycles-1. Floor of 1 bit keeps the
   // declaration legal for the degenerate minimum.
   function automatic int ps2_cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_timeout_cnt
//  Description : Watchdog for stalled prefix sequences. Counts cycles while
//                the parser sits in a prefix state and flags the cycle on
//                which the count reaches TIMEOUT_CYCLES-1.
//  Ports       : clk       - system clock
//                reset     - asynchronous active-high reset
//                clr_i     - restart the count from zero at the next edge
//                run_i     - parser is in a prefix state; count while high
//                expired_o - high for the cycle where the limit is reached
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_timeout_cnt
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int                CNT_W    = ps2_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Held at zero outside prefix states; saturates at the limit so a
   // missed clear can never wrap into a second false expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !run_i) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = run_i && (cnt_q == CNT_LAST);

endmodule : ps2_timeout_cnt
`default_nettype wire

// File: rtl/ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_ctrl
//  Description : Parses the PS/2 byte stream (make, E0 prefix, F0 prefix),
//                strobes accepted make codes into the holding register,
//                flags releases and protocol errors, optionally filters
//                typematic repeats of the held key, and abandons stalled
//                prefix sequences after TIMEOUT_CYCLES.
//  Ports       : clk            - system clock
//                reset          - asynchronous active-high reset
//                rx_done_tick_i - byte strobe, rx_data_i valid
//                rx_data_i      - received byte
//                reg_en_o       - one-cycle enable for an accepted make
//                reg_code_o     - key code, valid with reg_en_o/brk_tick_o
//                ext_o          - code was E0-prefixed
//                brk_tick_o     - one-cycle key release strobe
//                err_tick_o     - one-cycle timeout / illegal prefix strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_ctrl
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter bit REPEAT_FILTER  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick_i,
   input  logic [7:0] rx_data_i,
   output logic       reg_en_o,
   output logic [7:0] reg_code_o,
   output logic       ext_o,
   output logic       brk_tick_o,
   output logic       err_tick_o
);

   ps2_state_e state_q, state_d;
   logic       reg_en_q, reg_en_d;
   logic       brk_q, brk_d;
   logic       err_q, err_d;
   logic [7:0] code_q, code_d;
   logic       ext_q, ext_d;
   logic       held_valid_q, held_valid_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_ext_q, held_ext_d;

   logic       mk_req;
   logic       mk_ext;
   logic       brk_ext;
   logic       is_prefix;
   logic       expired;

   assign is_prefix = (rx_data_i == PS2_EXT) || (rx_data_i == PS2_BRK);

   // Any consumed byte restarts the window; an expiry also clears so the
   // counter is back at zero on the first IDLE cycle.
   ps2_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (rx_done_tick_i || expired),
      .run_i     (state_q != IDLE),
      .expired_o (expired)
   );

   always_comb begin
      state_d      = state_q;
      reg_en_d     = 1'b0;
      brk_d        = 1'b0;
      err_d        = 1'b0;
      code_d       = code_q;
      ext_d        = ext_q;
      held_valid_d = held_valid_q;
      held_code_d  = held_code_q;
      held_ext_d   = held_ext_q;
      mk_req       = 1'b0;
      mk_ext       = 1'b0;
      brk_ext      = (state_q == EXT_BRK);

      // A byte on the expiring cycle takes priority over the timeout.
      if (rx_done_tick_i) begin
         case (state_q)
            IDLE: begin
               if (rx_data_i == PS2_EXT) begin
                  state_d = EXT;
               end else if (rx_data_i == PS2_BRK) begin
                  state_d = BRK;
               end else begin
                  mk_req = 1'b1;
               end
            end
            EXT: begin
               if (rx_data_i == PS2_BRK) begin
                  state_d = EXT_BRK;
               end else if (rx_data_i != PS2_EXT) begin
                  mk_req  = 1'b1;
                  mk_ext  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               if (is_prefix) begin
                  err_d = 1'b1;
               end else begin
                  brk_d  = 1'b1;
                  code_d = rx_data_i;
                  ext_d  = brk_ext;
                  if (held_valid_q && (held_ext_q == brk_ext) &&
                      (held_code_q == rx_data_i)) begin
                     held_valid_d = 1'b0;
                  end
               end
            end
         endcase
      end else if (expired) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end

      if (mk_req) begin
         if (!(REPEAT_FILTER && held_valid_q && (held_ext_q == mk_ext) &&
               (held_code_q == rx_data_i))) begin
            reg_en_d     = 1'b1;
            code_d       = rx_data_i;
            ext_d        = mk_ext;
            held_valid_d = 1'b1;
            held_code_d  = rx_data_i;
            held_ext_d   = mk_ext;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         reg_en_q     <= 1'b0;
         brk_q        <= 1'b0;
         err_q        <= 1'b0;
         code_q       <= 8'h00;
         ext_q        <= 1'b0;
         held_valid_q <= 1'b0;
         held_code_q  <= 8'h00;
         held_ext_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         reg_en_q     <= reg_en_d;
         brk_q        <= brk_d;
         err_q        <= err_d;
         code_q       <= code_d;
         ext_q        <= ext_d;
         held_valid_q <= held_valid_d;
         held_code_q  <= held_code_d;
         held_ext_q   <= held_ext_d;
      end
   end

   assign reg_en_o   = reg_en_q;
   assign reg_code_o = code_q;
   assign ext_o      = ext_q;
   assign brk_tick_o = brk_q;
   assign err_tick_o = err_q;

endmodule : ps2_scan_ctrl
`default_nettype wire

// File: tb/tb_ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scan_ctrl
//  Description : Self-checking bench for ps2_scan_ctrl. Two instances run on
//                the same byte stream, one with repeat filtering and one
//                without, each compared every cycle against a byte-level
//                reference model of the PS/2 scan-code rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_ctrl;

   localparam int TO = 16;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b0;
   logic [7:0] data  = 8'h00;

   logic [1:0] en, brk, err, ext;
   logic [7:0] code [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ps2_scan_ctrl #(.TIMEOUT_CYCLES(TO), .REPEAT_FILTER(1'b1)) dut_f (
      .clk(clk), .reset(reset), .rx_done_tick_i(rx), .rx_data_i(data),
      .reg_en_o(en[0]), .reg_code_o(code[0]), .ext_o(ext[0]),
      .brk_tick_o(brk[0]), .err_tick_o(err[0]));

   ps2_scan_ctrl #(.TIMEOUT_CYCLES(TO), .REPEAT_FILTER(1'b0)) dut_n (
      .clk(clk), .reset(reset), .rx_done_tick_i(rx), .rx_data_i(data),
      .reg_en_o(en[1]), .reg_code_o(code[1]), .ext_o(ext[1]),
      .brk_tick_o(brk[1]), .err_tick_o(err[1]));

   // ---------------- reference model (index 0 filtered, 1 unfiltered) ----
   bit         pend_e0 [2];   // E0 seen and not yet consumed
   bit         pend_f0 [2];   // F0 seen and not yet consumed
   int         age     [2];   // cycles spent waiting on the current prefix
   bit         hv      [2];
   bit         hx      [2];
   logic [7:0] hc      [2];
   bit         x_en [2], x_brk [2], x_err [2], x_ext [2];
   logic [7:0] x_code [2];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         pend_e0[m] = 0; pend_f0[m] = 0; age[m] = 0;
         hv[m] = 0; hx[m] = 0; hc[m] = 8'h00;
         x_en[m] = 0; x_brk[m] = 0; x_err[m] = 0; x_ext[m] = 0; x_code[m] = 8'h00;
      end
   endfunction

   function automatic void model_step(input bit r, input logic [7:0] d);
      for (int m = 0; m < 2; m++) begin
         bit waiting;
         waiting  = pend_e0[m] || pend_f0[m];
         x_en[m]  = 0;
         x_brk[m] = 0;
         x_err[m] = 0;
         if (r) begin
            age[m] = 0;
            if (pend_f0[m]) begin
               if (d == 8'hE0 || d == 8'hF0) begin
                  x_err[m] = 1;
               end else begin
                  x_brk[m]  = 1;
                  x_code[m] = d;
                  x_ext[m]  = pend_e0[m];
                  if (hv[m] && hx[m] == pend_e0[m] && hc[m] == d) hv[m] = 0;
               end
               pend_e0[m] = 0;
               pend_f0[m] = 0;
            end else if (d == 8'hF0) begin
               pend_f0[m] = 1;
            end else if (d == 8'hE0) begin
               pend_e0[m] = 1;
            end else begin
               bit e;
               e = pend_e0[m];
               pend_e0[m] = 0;
               if (!(m == 0 && hv[m] && hx[m] == e && hc[m] == d)) begin
                  x_en[m] = 1; x_code[m] = d; x_ext[m] = e;
                  hv[m] = 1; hx[m] = e; hc[m] = d;
               end
            end
         end else if (waiting) begin
            if (age[m] == TO - 1) begin
               x_err[m]   = 1;
               pend_e0[m] = 0;
               pend_f0[m] = 0;
               age[m]     = 0;
            end else begin
               age[m]++;
            end
         end
      end
   endfunction

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         check_eq($sformatf("reg_en%0d", m),   en[m],   x_en[m]);
         check_eq($sformatf("brk_tick%0d", m), brk[m],  x_brk[m]);
         check_eq($sformatf("err_tick%0d", m), err[m],  x_err[m]);
         check_eq($sformatf("reg_code%0d", m), code[m], x_code[m]);
         check_eq($sformatf("ext%0d", m),      ext[m],  x_ext[m]);
         check_eq($sformatf("onehot%0d", m),
                  32'(en[m]) + 32'(brk[m]) + 32'(err[m]) <= 1, 1);
      end
   endtask

   // Present one cycle of input, then check the registered response.
   task automatic cycle(input bit r, input logic [7:0] d);
      rx   = r;
      data = d;
      model_step(r, d);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      rx    = 1'b0;
      model_reset();
      #1;
      compare_all();
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all();
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, d);
   endtask

   initial begin
      int en_cnt;
      apply_reset(2);

      // make then release
      send(8'h1C); send(8'hF0); send(8'h1C);
      // extended make and extended release
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);

      // typematic repeat: filtered instance strobes once, other thrice
      en_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         send(8'h1C);
         if (en[0]) en_cnt += 1;
         if (en[1]) en_cnt += 16;
      end
      check_eq("repeat_cnt", en_cnt, 1 + 3 * 16);
      send(8'hF0); send(8'h1C); send(8'h1C);
      check_eq("make_after_brk", en[0], 1);

      // timeout after F0 with a silent line
      send(8'hF0);
      repeat (TO) cycle(1'b0, 8'h00);
      check_eq("to_err", err[0], 1);
      send(8'h2B);
      check_eq("to_then_make", code[0], 8'h2B);

      // byte on the expiring cycle is processed
      send(8'hF0);
      repeat (TO - 1) cycle(1'b0, 8'h00);
      send(8'h2B);
      check_eq("to_edge_brk", brk[0], 1);
      cycle(1'b0, 8'h00);

      // illegal prefix after F0, repeated E0
      send(8'hF0); send(8'hE0);
      send(8'hE0); send(8'hE0); send(8'h1F);

      // reset mid-prefix
      send(8'hE0); send(8'hF0);
      apply_reset(2);
      send(8'h74);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int k;
         k = $urandom_range(0, 99);
         if (k < 2) begin
            apply_reset($urandom_range(1, 3));
         end else if (k < 7) begin
            repeat ($urandom_range(TO - 4, TO + 2)) cycle(1'b0, 8'h00);
         end else if (k < 25) begin
            cycle(1'b0, 8'($urandom));
         end else begin
            int p;
            logic [7:0] b;
            p = $urandom_range(0, 9);
            if (p < 2)      b = 8'hE0;
            else if (p < 4) b = 8'hF0;
            else if (p < 7) b = (p == 4) ? 8'h1C : 8'h75;
            else            b = 8'($urandom);
            send(b);
         end
      end

      cycle(1'b0, 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ps2_scan_ctrl
`default_nettype wire

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Sequencer between the PS/2 byte receiver and the 8-bit scan-code holding register. Parses the raw byte stream (make, 0xE0 extended prefix, 0xF0 break prefix), issues a one-cycle enable and code to the holding register only for accepted make codes, and flags key releases and protocol errors. Optionally suppresses typematic repeats of the key currently held, and abandons stalled prefix sequences via a timeout.

## Interface
- TIMEOUT_CYCLES, 1_000_000: max cycles allowed between a prefix byte and the next byte (10 ms at 100 MHz); must be ≥ 2.
- REPEAT_FILTER, 1: 1 suppresses repeated make of the held key; 0 passes every make.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_done_tick  in  1  one-cycle strobe, rx_data valid; may assert on consecutive cycles.
- rx_data  in  8  received byte.
- reg_en  out  1  one-cycle enable to holding register (accepted make).
- reg_code  out  8  code to holding register; valid when reg_en or brk_tick is high, held otherwise.
- ext  out  1  qualifies reg_code: 1 = code was E0-prefixed.
- brk_tick  out  1  one-cycle release strobe; reg_code/ext carry the released key.
- err_tick  out  1  one-cycle strobe: timeout or illegal byte after a prefix.

## Operation
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Held-key tracker: held_valid, held_code[7:0], held_ext.
- All actions occur only on cycles with rx_done_tick = 1, except timeout.
- IDLE: 0xE0 → EXT; 0xF0 → BRK; other byte b → make(b, ext=0), stay IDLE.
- EXT: 0xF0 → EXT_BRK; 0xE0 → stay EXT, timeout restarts; other b → make(b, ext=1), → IDLE.
- BRK / EXT_BRK: 0xE0 or 0xF0 → err_tick, → IDLE, no release. Other b → brk_tick, reg_code=b, ext=0 (BRK) or 1 (EXT_BRK), → IDLE; if held_valid and {held_ext,held_code} matches, clear held_valid.
- make(b,e): if REPEAT_FILTER=1 and held_valid and {held_ext,held_code}=={e,b} → no output. Otherwise reg_en=1, reg_code=b, ext=e; held ← {1,e,b} (new key replaces any held key).
- Timeout: counter clears on entry to EXT/BRK/EXT_BRK and on every accepted byte; counts each cycle in those states; at TIMEOUT_CYCLES-1 without rx_done_tick → err_tick, → IDLE. rx_done_tick on that same cycle wins: byte processed, no error.
- Counter idle (held at 0) in IDLE.

## Timing
- All outputs registered. Byte sampled at edge N (rx_done_tick high in cycle N) → reg_en/brk_tick/err_tick high in cycle N+1 for exactly one cycle; reg_code/ext update at the same edge and hold until next strobe.
- Back-to-back bytes on consecutive cycles processed in order, one per cycle, no drop.
- At most one of reg_en, brk_tick, err_tick high in any cycle.
- Reset (any time, including mid-prefix): state IDLE, reg_en=0, brk_tick=0, err_tick=0, reg_code=8'h00, ext=0, held_valid=0, counter=0. First byte after reset release is parsed from IDLE.

## Structure
- Shared package ps2_pkg: state enum (IDLE, EXT, BRK, EXT_BRK), constants PS2_EXT=8'hE0, PS2_BRK=8'hF0; counter width = $clog2(TIMEOUT_CYCLES).
- Sub-module ps2_timeout_cnt (params TIMEOUT_CYCLES; in clk, reset, clr, run; out expired one-cycle pulse). FSM, held tracker and output registers live in ps2_scan_ctrl.

## Test plan
- Bytes 1C → reg_en one cycle after strobe, reg_code=1C, ext=0; then F0,1C → brk_tick, reg_code=1C, held cleared.
- E0,75 then E0,F0,75 → reg_en with code 75 ext=1, then brk_tick code 75 ext=1.
- REPEAT_FILTER=1: 1C,1C,1C → single reg_en; REPEAT_FILTER=0 → three reg_en; after F0,1C, next 1C → reg_en again.
- TIMEOUT_CYCLES=16: F0 then idle 15 cycles → err_tick, state IDLE; next 2B → reg_en code 2B. Byte arriving exactly on the expiring cycle → processed, no err_tick.
- F0,E0 → err_tick, no brk_tick; E0,E0,1F → reg_en code 1F ext=1.
- Reset asserted after E0,F0 → all outputs 0; after release byte 74 → reg_en code 74 ext=0.
